// File: rtl/dcache_pkg.sv
// Shared definitions for the Dcache miss path: line geometry and miss FSM encoding.
package dcache_pkg;

    localparam int LINE_BYTES  = 16;
    localparam int LINE_BITS   = LINE_BYTES * 8;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);

    // Clears the byte-offset bits so an address points at the start of its line
    localparam logic [31:0] LINE_MASK = ~32'((1 << OFFSET_BITS) - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WB_REQ  = 3'd1;
    localparam logic [2:0] ST_WB_WAIT = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_WB_REQ  = ST_WB_REQ,
        S_WB_WAIT = ST_WB_WAIT,
        S_RD_REQ  = ST_RD_REQ,
        S_RD_WAIT = ST_RD_WAIT,
        S_RESP    = ST_RESP
    } state_e;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Saturating wait-cycle counter for memory request watchdogs; hit_o flags the
// final permitted wait cycle (count == LIMIT-1) so the caller can abort on it.
module mem_req_timer #(
    parameter int W     = 8,
    parameter int LIMIT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic         hit_o
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    // Clear has priority over load; increment stops at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit_o = (cnt_q >= LAST);

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Dcache miss controller: optional dirty-victim writeback, line refill, watchdog abort.
module dcache_mem_ctrl
    import dcache_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 miss_req_i,
    input  logic [31:0]          miss_addr_i,
    input  logic                 victim_dirty_i,
    input  logic [31:0]          victim_addr_i,
    input  logic [LINE_BITS-1:0] victim_data_i,
    output logic                 busy_o,
    output logic                 refill_valid_o,
    output logic [LINE_BITS-1:0] refill_data_o,
    output logic                 err_o,
    output logic                 Dcache_rd_req_o,
    output logic [31:0]          Dcache_rd_addr_o,
    output logic                 Dcache_wb_req_o,
    output logic [31:0]          Dcache_wb_addr_o,
    output logic [LINE_BITS-1:0] Dcache_wb_data_o,
    input  logic [LINE_BITS-1:0] ram_data_i,
    input  logic                 ram_ready_i
);

    state_e               state_q;
    logic [31:0]          rd_addr_q;
    logic [31:0]          wb_addr_q;
    logic [LINE_BITS-1:0] wb_data_q;
    logic [LINE_BITS-1:0] refill_q;
    logic                 busy_q;
    logic                 rd_req_q;
    logic                 wb_req_q;
    logic                 valid_q;
    logic                 err_q;

    logic tmr_clr;
    logic tmr_inc;
    logic tmr_hit;

    // Counter restarts in each request cycle and counts every un-acknowledged wait cycle
    assign tmr_clr = (state_q == S_WB_REQ) || (state_q == S_RD_REQ);
    assign tmr_inc = ((state_q == S_WB_WAIT) || (state_q == S_RD_WAIT)) && !ram_ready_i;

    mem_req_timer #(
        .W     (8),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (tmr_clr),
        .load_i     (1'b0),
        .load_val_i (8'd0),
        .inc_i      (tmr_inc),
        .hit_o      (tmr_hit)
    );

    // Miss FSM; every output is registered and set on entry to the state that owns it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            refill_q  <= '0;
            busy_q    <= 1'b0;
            rd_req_q  <= 1'b0;
            wb_req_q  <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_req_q <= 1'b0;
            wb_req_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (miss_req_i) begin
                        rd_addr_q <= line_align(miss_addr_i);
                        wb_addr_q <= line_align(victim_addr_i);
                        wb_data_q <= victim_data_i;
                        busy_q    <= 1'b1;
                        if (victim_dirty_i) begin
                            state_q  <= S_WB_REQ;
                            wb_req_q <= 1'b1;
                        end else begin
                            state_q  <= S_RD_REQ;
                            rd_req_q <= 1'b1;
                        end
                    end
                end
                S_WB_REQ: state_q <= S_WB_WAIT;
                S_WB_WAIT: begin
                    if (ram_ready_i) begin
                        state_q  <= S_RD_REQ;
                        rd_req_q <= 1'b1;
                    end else if (tmr_hit) begin
                        state_q  <= S_RESP;
                        valid_q  <= 1'b1;
                        err_q    <= 1'b1;
                        refill_q <= '0;
                    end
                end
                S_RD_REQ: state_q <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (ram_ready_i) begin
                        state_q  <= S_RESP;
                        valid_q  <= 1'b1;
                        refill_q <= ram_data_i;
                    end else if (tmr_hit) begin
                        state_q  <= S_RESP;
                        valid_q  <= 1'b1;
                        err_q    <= 1'b1;
                        refill_q <= '0;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign refill_valid_o   = valid_q;
    assign refill_data_o    = refill_q;
    assign err_o            = err_q;
    assign Dcache_rd_req_o  = rd_req_q;
    assign Dcache_rd_addr_o = rd_addr_q;
    assign Dcache_wb_req_o  = wb_req_q;
    assign Dcache_wb_addr_o = wb_addr_q;
    assign Dcache_wb_data_o = wb_data_q;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl with a line-granular RAM model and refill scoreboard.
module tb_dcache_mem_ctrl;

  localparam int TO = 4;
  localparam logic [127:0] PAT120 = 128'h0F0E0D0C0B0A09080706050403020100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_req_i = 1'b0;
  logic [31:0]  miss_addr_i = '0;
  logic         victim_dirty_i = 1'b0;
  logic [31:0]  victim_addr_i = '0;
  logic [127:0] victim_data_i = '0;
  logic         busy_o;
  logic         refill_valid_o;
  logic [127:0] refill_data_o;
  logic         err_o;
  logic         Dcache_rd_req_o;
  logic [31:0]  Dcache_rd_addr_o;
  logic         Dcache_wb_req_o;
  logic [31:0]  Dcache_wb_addr_o;
  logic [127:0] Dcache_wb_data_o;
  logic [127:0] ram_data_i;
  logic         ram_ready_i;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok,
                     input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (!ok) begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  dcache_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_req_i       (miss_req_i),
    .miss_addr_i      (miss_addr_i),
    .victim_dirty_i   (victim_dirty_i),
    .victim_addr_i    (victim_addr_i),
    .victim_data_i    (victim_data_i),
    .busy_o           (busy_o),
    .refill_valid_o   (refill_valid_o),
    .refill_data_o    (refill_data_o),
    .err_o            (err_o),
    .Dcache_rd_req_o  (Dcache_rd_req_o),
    .Dcache_rd_addr_o (Dcache_rd_addr_o),
    .Dcache_wb_req_o  (Dcache_wb_req_o),
    .Dcache_wb_addr_o (Dcache_wb_addr_o),
    .Dcache_wb_data_o (Dcache_wb_data_o),
    .ram_data_i       (ram_data_i),
    .ram_ready_i      (ram_ready_i)
  );

  // RAM model: 256 lines indexed by addr[11:4]; ready one cycle after a request
  logic [127:0] mem [0:255];
  logic         ram_en = 1'b1;
  logic         stray_rdy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_ready_i <= 1'b0;
      ram_data_i  <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= {16{i[7:0]}};
      mem[8'h12] <= PAT120;
    end else begin
      ram_ready_i <= stray_rdy;
      if (ram_en && Dcache_rd_req_o) begin
        ram_ready_i <= 1'b1;
        ram_data_i  <= mem[Dcache_rd_addr_o[11:4]];
      end
      if (ram_en && Dcache_wb_req_o) begin
        mem[Dcache_wb_addr_o[11:4]] <= Dcache_wb_data_o;
        ram_ready_i <= 1'b1;
      end
    end
  end

  // Monitor: request-pulse rules, address/data at pulses, scoreboard for refills
  logic [128:0] sb[$];
  logic [128:0] sb_e;
  int           rd_cnt = 0;
  int           wb_cnt = 0;
  int           wb_base = 0;
  logic         prev_rd = 1'b0;
  logic         prev_wb = 1'b0;
  logic [31:0]  exp_rd_addr = '0;
  logic [31:0]  exp_wb_addr = '0;
  logic [127:0] exp_wb_data = '0;
  logic         exp_dirty = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (Dcache_rd_req_o || Dcache_wb_req_o)
        chk("req_overlap", (Dcache_rd_req_o & Dcache_wb_req_o) === 1'b0,
            Dcache_rd_req_o & Dcache_wb_req_o, 1'b0);
      if (Dcache_rd_req_o) begin
        chk("rd_req_single", prev_rd === 1'b0, prev_rd, 1'b0);
        chk("rd_addr", Dcache_rd_addr_o === exp_rd_addr, Dcache_rd_addr_o, exp_rd_addr);
        if (exp_dirty)
          chk("wb_before_rd", (wb_cnt - wb_base) == 1, wb_cnt - wb_base, 1);
        rd_cnt++;
      end
      if (Dcache_wb_req_o) begin
        chk("wb_req_single", prev_wb === 1'b0, prev_wb, 1'b0);
        chk("wb_addr", Dcache_wb_addr_o === exp_wb_addr, Dcache_wb_addr_o, exp_wb_addr);
        chk("wb_data", Dcache_wb_data_o === exp_wb_data, Dcache_wb_data_o, exp_wb_data);
        wb_cnt++;
      end
      if (err_o)
        chk("err_with_valid", refill_valid_o === 1'b1, refill_valid_o, 1'b1);
      if (refill_valid_o) begin
        chk("refill_expected", sb.size() != 0, sb.size(), 1);
        if (sb.size() != 0) begin
          sb_e = sb.pop_front();
          chk("refill_data", refill_data_o === sb_e[127:0], refill_data_o, sb_e[127:0]);
          chk("refill_err", err_o === sb_e[128], err_o, sb_e[128]);
        end
      end
    end
    prev_rd <= Dcache_rd_req_o;
    prev_wb <= Dcache_wb_req_o;
  end

  // One miss transaction from an idle negedge; latency counted in negedges to refill_valid_o
  task automatic do_miss(input logic [31:0] maddr, input logic dirty,
                         input logic [31:0] vaddr, input logic [127:0] vdata,
                         input logic [127:0] exp_data, input logic exp_err,
                         input int exp_lat, input logic perturb, input logic hold);
    int lat;
    int rd0;
    int wb0;
    sb.push_back({exp_err, exp_data});
    exp_rd_addr = maddr & ~32'hF;
    exp_wb_addr = vaddr & ~32'hF;
    exp_wb_data = vdata;
    exp_dirty   = dirty;
    rd0 = rd_cnt;
    wb0 = wb_cnt;
    wb_base = wb_cnt;
    miss_req_i     = 1'b1;
    miss_addr_i    = maddr;
    victim_dirty_i = dirty;
    victim_addr_i  = vaddr;
    victim_data_i  = vdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (perturb && lat == 2) begin
        miss_addr_i    = 32'h0000_0500;
        victim_dirty_i = 1'b1;
      end
    end while (!refill_valid_o && lat < 40);
    if (!hold) miss_req_i = 1'b0;
    chk("latency", lat == exp_lat, lat, exp_lat);
    chk("busy_in_resp", busy_o === 1'b1, busy_o, 1'b1);
    chk("rd_addr_stable", Dcache_rd_addr_o === exp_rd_addr, Dcache_rd_addr_o, exp_rd_addr);
    chk("rd_pulses", (rd_cnt - rd0) == 1, rd_cnt - rd0, 1);
    chk("wb_pulses", (wb_cnt - wb0) == (dirty ? 1 : 0), wb_cnt - wb0, dirty ? 1 : 0);
    if (!hold) begin
      @(negedge clk);
      chk("busy_idle", busy_o === 1'b0, busy_o, 1'b0);
    end
  endtask

  initial begin
    int rd0;
    int wb0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o === 1'b0, busy_o, 1'b0);
    chk("rst_valid", refill_valid_o === 1'b0, refill_valid_o, 1'b0);
    chk("rst_err", err_o === 1'b0, err_o, 1'b0);
    chk("rst_rd_req", Dcache_rd_req_o === 1'b0, Dcache_rd_req_o, 1'b0);
    chk("rst_wb_req", Dcache_wb_req_o === 1'b0, Dcache_wb_req_o, 1'b0);
    chk("rst_refill", refill_data_o === 128'h0, refill_data_o, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_miss(32'h0000_0127, 1'b0, 32'h0, 128'h0, PAT120, 1'b0, 3, 1'b0, 1'b0);

    do_miss(32'h0000_0300, 1'b1, 32'h0000_0200, {16{8'hAA}}, {16{8'h30}}, 1'b0, 5, 1'b0, 1'b0);
    do_miss(32'h0000_0200, 1'b0, 32'h0, 128'h0, {16{8'hAA}}, 1'b0, 3, 1'b0, 1'b0);

    ram_en = 1'b0;
    do_miss(32'h0000_0400, 1'b0, 32'h0, 128'h0, 128'h0, 1'b1, 2 + TO, 1'b0, 1'b0);
    ram_en = 1'b1;
    do_miss(32'h0000_0127, 1'b0, 32'h0, 128'h0, PAT120, 1'b0, 3, 1'b0, 1'b0);

    do_miss(32'h0000_0127, 1'b0, 32'h0, 128'h0, PAT120, 1'b0, 3, 1'b1, 1'b0);
    victim_dirty_i = 1'b0;

    rd0 = rd_cnt;
    wb0 = wb_cnt;
    stray_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_busy", busy_o === 1'b0, busy_o, 1'b0);
    end
    stray_rdy = 1'b0;
    @(negedge clk);
    chk("stray_rd_pulses", (rd_cnt - rd0) == 0, rd_cnt - rd0, 0);
    chk("stray_wb_pulses", (wb_cnt - wb0) == 0, wb_cnt - wb0, 0);

    do_miss(32'h0000_0127, 1'b0, 32'h0, 128'h0, PAT120, 1'b0, 3, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_busy_gap", busy_o === 1'b0, busy_o, 1'b0);
    do_miss(32'h0000_0300, 1'b0, 32'h0, 128'h0, {16{8'h30}}, 1'b0, 3, 1'b0, 1'b0);

    ram_en         = 1'b0;
    exp_wb_addr    = 32'h0000_0200;
    exp_wb_data    = {16{8'h55}};
    exp_dirty      = 1'b1;
    miss_req_i     = 1'b1;
    miss_addr_i    = 32'h0000_0120;
    victim_dirty_i = 1'b1;
    victim_addr_i  = 32'h0000_0208;
    victim_data_i  = {16{8'h55}};
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy_o === 1'b1, busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o === 1'b0, busy_o, 1'b0);
    chk("arst_wb_addr", Dcache_wb_addr_o === 32'h0, Dcache_wb_addr_o, 32'h0);
    chk("arst_wb_data", Dcache_wb_data_o === 128'h0, Dcache_wb_data_o, 128'h0);
    chk("arst_rd_addr", Dcache_rd_addr_o === 32'h0, Dcache_rd_addr_o, 32'h0);
    chk("arst_refill", refill_data_o === 128'h0, refill_data_o, 128'h0);
    chk("arst_valid", refill_valid_o === 1'b0, refill_valid_o, 1'b0);
    miss_req_i     = 1'b0;
    victim_dirty_i = 1'b0;
    ram_en         = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_valid", refill_valid_o === 1'b0, refill_valid_o, 1'b0);
    end
    do_miss(32'h0000_0127, 1'b0, 32'h0, 128'h0, PAT120, 1'b0, 3, 1'b0, 1'b0);
    chk("sb_drained", sb.size() == 0, sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
